// File: rtl/pool_map_sink.sv
// rtl/pool_map_sink.sv - layer1 pooled-result collector that streams the frame map to layer2
//
// Collects 1-bit pooled results by address into a frame bitmap. A write that
// carries last_in closes the frame. The bitmap is then streamed out as packed
// DATA_W-bit words over a valid/ready handshake. After the final word the
// block clears the bitmap and re-arms for the next frame.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   wr_en            pooled result valid this cycle
//   res_in           pooled result bit
//   addr_in          pooled result address
//   last_in          final result of the frame, qualified by wr_en
//   m_valid          output word valid (high for the whole stream)
//   m_ready          downstream ready
//   m_data           packed map bits; bit k = map address idx*DATA_W+k
//   m_last           marks the final word
//   busy             high while streaming
//   frame_done       one-cycle pulse when a frame closes
//   err_oor          sticky: write seen with addr_in >= MAP_DEPTH
//   err_ovf          sticky: write attempted while streaming
//   err_cnt          (COUNT_CHECK_EN only) sticky: a frame closed with an
//                    in-range write count different from MAP_DEPTH
//
// Optional feature macro: COUNT_CHECK_EN

module pool_map_sink #(
    parameter int MAP_DEPTH = 1014,
    parameter int ADDR_W    = 13,
    parameter int DATA_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              res_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              last_in,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              frame_done,
    output logic              err_oor,
`ifdef COUNT_CHECK_EN
    output logic              err_ovf,
    output logic              err_cnt
`else
    output logic              err_ovf
`endif
);

    localparam int NWORDS = (MAP_DEPTH + DATA_W - 1) / DATA_W;
    localparam int PAD_W  = NWORDS * DATA_W;
    localparam int BIT_W  = (PAD_W > 1) ? $clog2(PAD_W) : 1;
    localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NWORDS - 1);
    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(MAP_DEPTH);

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_STREAM  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    // Padded to whole words; padding bits are never written so they read 0.
    logic [PAD_W-1:0]   bitmap_q, bitmap_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               m_valid_q, m_valid_d;
    logic [DATA_W-1:0]  m_data_q, m_data_d;
    logic               m_last_q, m_last_d;
    logic               busy_q, busy_d;
    logic               frame_done_q, frame_done_d;
    logic               err_oor_q, err_oor_d;
    logic               err_ovf_q, err_ovf_d;

    logic               in_range;
    logic [BIT_W-1:0]   wr_bit;
    logic [DATA_W-1:0]  words_d [NWORDS];

    assign in_range = ({1'b0, addr_in} < DEPTH_C);
    assign wr_bit   = BIT_W'(addr_in);

    always_comb begin
        state_d      = state_q;
        bitmap_d     = bitmap_q;
        idx_d        = idx_q;
        frame_done_d = 1'b0;
        err_oor_d    = err_oor_q;
        err_ovf_d    = err_ovf_q;

        case (state_q)
            S_COLLECT: begin
                if (wr_en) begin
                    if (in_range) begin
                        bitmap_d[wr_bit] = res_in;
                    end else begin
                        err_oor_d = 1'b1;
                    end
                    if (last_in) begin
                        state_d      = S_STREAM;
                        frame_done_d = 1'b1;
                        idx_d        = '0;
                    end
                end
            end
            S_STREAM: begin
                if (wr_en) begin
                    err_ovf_d = 1'b1;
                end
                if (m_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d  = S_COLLECT;
                        bitmap_d = '0;
                        idx_d    = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = S_COLLECT;
        endcase

        // Word select uses the next-state bitmap so the closing write is
        // already visible in word 0 on the first stream cycle.
        for (int w = 0; w < NWORDS; w++) begin
            words_d[w] = bitmap_d[w*DATA_W +: DATA_W];
        end

        m_valid_d = (state_d == S_STREAM);
        busy_d    = (state_d == S_STREAM);
        m_last_d  = (state_d == S_STREAM) && (idx_d == LAST_IDX);
        m_data_d  = (state_d == S_STREAM) ? words_d[idx_d] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_COLLECT;
            bitmap_q     <= '0;
            idx_q        <= '0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_last_q     <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            err_oor_q    <= 1'b0;
            err_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bitmap_q     <= bitmap_d;
            idx_q        <= idx_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_last_q     <= m_last_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            err_oor_q    <= err_oor_d;
            err_ovf_q    <= err_ovf_d;
        end
    end

    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign m_last     = m_last_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign err_oor    = err_oor_q;
    assign err_ovf    = err_ovf_q;

`ifdef COUNT_CHECK_EN
    localparam int CNT_W = $clog2(MAP_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAP_DEPTH);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_cnt_q, err_cnt_d;

    always_comb begin
        cnt_d     = cnt_q;
        err_cnt_d = err_cnt_q;
        if (state_q == S_COLLECT && wr_en) begin
            // Saturate so a flood of rewrites cannot wrap back to MAP_DEPTH.
            if (in_range && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (last_in && (cnt_d != CNT_FULL)) begin
                err_cnt_d = 1'b1;
            end
        end
        // Fresh count for the frame that starts when streaming ends.
        if (state_q == S_STREAM && state_d == S_COLLECT) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            err_cnt_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule
